// File: rtl/contador_pkg.sv
// Shared encodings for the round-robin counter arbiter: counter ops and FSM states.
package contador_pkg;

  typedef enum logic [1:0] {
    OP_UP   = 2'b00,
    OP_DN   = 2'b01,
    OP_DN3  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/arbitro_contador_if.sv
// Requester-side command bundle: per-requester valid/op/data/steps with a per-requester ready.
interface arbitro_contador_if #(parameter int NSTEP = 8);
  logic [1:0]         req_valid;
  logic [3:0]         req_op;
  logic [7:0]         req_data;
  logic [2*NSTEP-1:0] req_steps;
  logic [1:0]         req_ready;

  modport master (output req_valid, req_op, req_data, req_steps, input req_ready);
  modport slave  (input req_valid, req_op, req_data, req_steps, output req_ready);
endinterface

// File: rtl/arbitro_rr2.sv
// Two-way round-robin grant, purely combinational; on a tie the requester that
// did not own the last operation wins.
module arbitro_rr2 (
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic       grant_vld,
  output logic       grant_idx
);
  always_comb begin
    grant_vld = |valid;
    grant_idx = 1'b0;
    case (valid)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_owner;
      default: grant_idx = 1'b0;
    endcase
  end
endmodule

// File: rtl/arbitro_contador.sv
// Arbitrates two requesters onto one 4-bit counter; an accepted command runs N enabled
// cycles, one drain cycle and one done cycle (done at T+N+2); ready only while IDLE.
module arbitro_contador
  import contador_pkg::*;
#(
  parameter int NSTEP = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [1:0]         req_valid,
  input  logic [3:0]         req_op,
  input  logic [7:0]         req_data,
  input  logic [2*NSTEP-1:0] req_steps,
  output logic [1:0]         req_ready,
  output logic               cnt_enb,
  output logic [1:0]         cnt_modo,
  output logic [3:0]         cnt_D,
  input  logic [3:0]         cnt_Q,
  input  logic               cnt_RCO,
  output logic               busy,
  output logic               owner,
  output logic [1:0]         done,
  output logic [3:0]         rco_count,
  output logic [3:0]         q_final
);
  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [NSTEP-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  op_e              modo_q, modo_d;
  logic [3:0]       data_q, data_d;
  logic [3:0]       rco_q, rco_d;
  logic [3:0]       qf_q, qf_d;

  logic             gnt_vld, gnt_idx, xfer, win_runs;
  op_e              win_op;
  logic [3:0]       win_data;
  logic [NSTEP-1:0] win_steps;

  arbitro_rr2 u_rr (
    .valid      (req_valid),
    .last_owner (last_q),
    .grant_vld  (gnt_vld),
    .grant_idx  (gnt_idx)
  );

  always_comb begin
    win_op    = op_e'(gnt_idx ? req_op[3:2] : req_op[1:0]);
    win_data  = gnt_idx ? req_data[7:4] : req_data[3:0];
    win_steps = gnt_idx ? req_steps[2*NSTEP-1:NSTEP] : req_steps[NSTEP-1:0];
    win_runs  = (win_op == OP_LOAD) || (win_steps != '0);
    xfer      = |req_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = win_runs ? RUN : DONE;
      RUN:     if (rem_q == NSTEP'(1)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    rem_d   = rem_q;
    first_d = first_q;
    modo_d  = modo_q;
    data_d  = data_q;
    rco_d   = rco_q;
    qf_d    = qf_q;
    if (xfer) begin
      owner_d = gnt_idx;
      last_d  = gnt_idx;
      rco_d   = 4'd0;
      first_d = 1'b1;
      rem_d   = (win_op == OP_LOAD) ? NSTEP'(1) : win_steps;
      // A zero-step command never drives the counter, so mode/data keep their old values.
      if (win_runs) begin
        modo_d = win_op;
        data_d = win_data;
      end
    end
    if (state_q == RUN) begin
      rem_d   = rem_q - NSTEP'(1);
      first_d = 1'b0;
    end
    // RCO seen in the first RUN cycle belongs to the previous operation.
    if (cnt_RCO && (((state_q == RUN) && !first_q) || (state_q == DRAIN)) && (rco_q != 4'hF))
      rco_d = rco_q + 4'd1;
    if (state_q == DRAIN)
      qf_d = cnt_Q;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rem_q   <= '0;
      first_q <= 1'b0;
      modo_q  <= OP_UP;
      data_q  <= 4'd0;
      rco_q   <= 4'd0;
      qf_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      modo_q  <= modo_d;
      data_q  <= data_d;
      rco_q   <= rco_d;
      qf_q    <= qf_d;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if ((state_q == IDLE) && reset_L && gnt_vld)
      req_ready = gnt_idx ? 2'b10 : 2'b01;
    cnt_enb   = (state_q == RUN);
    cnt_modo  = modo_q;
    cnt_D     = data_q;
    busy      = (state_q != IDLE);
    owner     = owner_q;
    done      = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    rco_count = rco_q;
    q_final   = qf_q;
  end
endmodule
